// File: rtl/dmem_responder_if.sv
// ----------------------------------------------------------------------------
// dmem_responder_if
// Purpose : Bundles the request and response valid/ready channels between the
//           core's load/store port (master) and the memory responder (slave).
// Signals :
//   req_valid / req_ready        request handshake
//   req_we, req_addr, req_wdata, request payload (store flag, byte address,
//   req_be                       store data, store byte enables)
//   rsp_valid / rsp_ready        response handshake
//   rsp_rdata, rsp_err           response payload (load data, error flag)
// ----------------------------------------------------------------------------
interface dmem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_responder.sv
// ----------------------------------------------------------------------------
// dmem_responder
// Purpose : Memory-side responder for a stalling load/store port. Accepts one
//           word request at a time, waits LATENCY cycles, performs the access
//           on an internal word array and returns load data or a store
//           acknowledge, flagging misaligned or out-of-range addresses.
// Params  : DEPTH_WORDS  words in the array (power of two, >= 2)
//           LATENCY      wait cycles between request accept and array access
// Ports   : CLK  clock, rising edge
//           RST  synchronous active-high reset
//           bus  dmem_responder_if.slave request/response channels
// ----------------------------------------------------------------------------
module dmem_responder #(
    parameter int DEPTH_WORDS = 64,
    parameter int LATENCY     = 2
) (
    input  logic             CLK,
    input  logic             RST,
    dmem_responder_if.slave  bus
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((LATENCY > 0) ? (LATENCY - 1) : 0);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [31:0]       addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [3:0]        be_q, be_d;
    logic              req_ready_q, req_ready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [31:0]       rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;

    logic [31:0]       mem_q [DEPTH_WORDS];

    // Access operands: with zero latency the access happens on the accept
    // edge itself, so the live request fields are used in IDLE; otherwise the
    // latched copy is used.
    logic              acc_s;
    logic              acc_we_s;
    logic [31:0]       acc_addr_s;
    logic [31:0]       acc_wdata_s;
    logic [3:0]        acc_be_s;
    logic [IDX_W-1:0]  acc_idx_s;
    logic              acc_err_s;
    logic              wr_en_s;

    // Select access operands and classify the address
    always_comb begin
        if (state_q == ST_IDLE) begin
            acc_we_s    = bus.req_we;
            acc_addr_s  = bus.req_addr;
            acc_wdata_s = bus.req_wdata;
            acc_be_s    = bus.req_be;
        end else begin
            acc_we_s    = we_q;
            acc_addr_s  = addr_q;
            acc_wdata_s = wdata_q;
            acc_be_s    = be_q;
        end
        acc_idx_s = acc_addr_s[2 +: IDX_W];
        // Word address >= DEPTH_WORDS is equivalent to any bit above the index
        // field being set, because DEPTH_WORDS is a power of two.
        acc_err_s = (acc_addr_s[1:0] != 2'b00) || (acc_addr_s[31:2+IDX_W] != '0);
    end

    // Next-state and output logic of the IDLE/WAIT/RESP controller
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        be_d        = be_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        acc_s       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid && req_ready_q) begin
                    we_d    = bus.req_we;
                    addr_d  = bus.req_addr;
                    wdata_d = bus.req_wdata;
                    be_d    = bus.req_be;
                    if (LATENCY == 0) begin
                        acc_s   = 1'b1;
                        state_d = ST_RESP;
                    end else begin
                        cnt_d   = CNT_LOAD;
                        state_d = ST_WAIT;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    acc_s   = 1'b1;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b0;
                    rsp_rdata_d = 32'h0000_0000;
                    rsp_err_d   = 1'b0;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (acc_s) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = acc_err_s;
            rsp_rdata_d = (!acc_err_s && !acc_we_s) ? mem_q[acc_idx_s] : 32'h0000_0000;
        end else begin
            rsp_valid_d = rsp_valid_d;
        end

        // Ready is registered from the next state so it never depends
        // combinationally on the request inputs.
        req_ready_d = (state_d == ST_IDLE);
    end

    // Gate the array write; reset on the access edge cancels the store
    always_comb begin
        wr_en_s = acc_s && acc_we_s && !acc_err_s && !RST;
    end

    // Controller, request latch and response registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            addr_q      <= 32'h0000_0000;
            wdata_q     <= 32'h0000_0000;
            be_q        <= 4'h0;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'h0000_0000;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            be_q        <= be_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Byte-lane write port; array contents deliberately survive reset
    always_ff @(posedge CLK) begin
        if (wr_en_s) begin
            for (int b = 0; b < 4; b++) begin
                if (acc_be_s[b]) begin
                    mem_q[acc_idx_s][8*b +: 8] <= acc_wdata_s[8*b +: 8];
                end
            end
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;

endmodule
